// File: rtl/led_scroll_ctrl_pkg.sv
// Shared types and constants for the seven-segment scroll controller.
// Anode vectors are ordered {an3, an2, an1, an0} and are active-low.
package led_disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] char_code_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } scroll_state_t;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [3:0] anode_sel(input digit_idx_t d);
        logic [3:0] an;
        unique case (d)
            2'd0:    an = AN_DIG0;
            2'd1:    an = AN_DIG1;
            2'd2:    an = AN_DIG2;
            default: an = AN_DIG3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/led_scroll_ctrl_if.sv
// Message-write handshake between one requester and the scroll controller.
// A write is accepted on a clock edge where wr_valid and wr_ready are both high.
interface led_scroll_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    import led_disp_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    char_code_t        wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/led_scroll_ctrl_refresh_timer.sv
// Digit-slot timer: refresh counter and current digit index (3 -> 2 -> 1 -> 0).
// With LED_SCROLL_GUARD_EN defined, anode enable lags the slot start by one cycle.
module led_refresh_timer
    import led_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    output digit_idx_t o_digit,
    output logic       o_slot_start,
    output logic       o_an_load
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_digit;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_digit <= 2'd3;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_digit <= r_digit - 2'd1;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_digit      = r_digit;
    assign o_slot_start = (r_cnt == '0);

`ifdef LED_SCROLL_GUARD_EN
    // Digit index is unchanged until the wrap, so cycle 1 still belongs to this slot.
    assign o_an_load = (r_cnt == CNT_W'(1));
`else
    assign o_an_load = o_slot_start;
`endif

endmodule

// File: rtl/led_scroll_ctrl.sv
// Four-digit display scheduler: message buffer, anode multiplexing, scroll FSM.
// Optional LED_SCROLL_GUARD_EN inserts one all-anodes-off cycle at each slot start.
module led_scroll_ctrl
    import led_disp_pkg::*;
#(
    parameter int unsigned MSG_LEN     = 16,
    parameter int unsigned REFRESH_DIV = 16,
    parameter int unsigned SCROLL_DIV  = 1024,
    parameter int unsigned HOLD_STEPS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    led_scroll_ctrl_if.slave        wr_if,
    input  logic                    i_scroll_en,
    output logic                    o_an3,
    output logic                    o_an2,
    output logic                    o_an1,
    output logic                    o_an0,
    output char_code_t              o_char,
    output logic                    o_step_pulse
);

    localparam int unsigned ADDR_W   = $clog2(MSG_LEN);
    localparam int unsigned SCR_W    = $clog2(SCROLL_DIV);
    localparam int unsigned HOLD_CYC = (HOLD_STEPS == 0) ? 1 : HOLD_STEPS * SCROLL_DIV;
    localparam int unsigned HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    char_code_t        r_mem [MSG_LEN];
    logic [ADDR_W-1:0] r_base;
    scroll_state_t     r_state;
    logic [SCR_W-1:0]  r_scroll_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_step_pulse;
    logic              r_wr_ready;
    logic [3:0]        r_an;
    char_code_t        r_char;

    scroll_state_t     w_state_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [SCR_W-1:0]  w_scroll_cnt_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              w_step;
    logic              w_wr_fire;
    digit_idx_t        w_digit;
    logic              w_slot_start;
    logic              w_an_load;
    logic [ADDR_W-1:0] w_rd_addr;

    led_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh (
        .clk          (clk),
        .reset        (reset),
        .o_digit      (w_digit),
        .o_slot_start (w_slot_start),
        .o_an_load    (w_an_load)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_scroll_cnt_nxt = r_scroll_cnt;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_step           = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_scroll_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!i_scroll_en) begin
                    w_state_nxt = IDLE;
                end else if (r_scroll_cnt == SCR_W'(SCROLL_DIV - 1)) begin
                    w_scroll_cnt_nxt = '0;
                    w_base_nxt       = r_base + ADDR_W'(1);
                    w_step           = 1'b1;
                    // Pause once the window has wrapped back to the message start.
                    if ((r_base == ADDR_W'(MSG_LEN - 1)) && (HOLD_STEPS != 0)) begin
                        w_state_nxt    = HOLD;
                        w_hold_cnt_nxt = '0;
                    end
                end else begin
                    w_scroll_cnt_nxt = r_scroll_cnt + SCR_W'(1);
                end
            end
            HOLD: begin
                if (!i_scroll_en) begin
                    w_state_nxt    = IDLE;
                    w_hold_cnt_nxt = '0;
                end else if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                    w_state_nxt      = RUN;
                    w_hold_cnt_nxt   = '0;
                    w_scroll_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_scroll_cnt <= '0;
            r_hold_cnt   <= '0;
            r_step_pulse <= 1'b0;
            r_wr_ready   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_base       <= w_base_nxt;
            r_scroll_cnt <= w_scroll_cnt_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_step_pulse <= w_step;
            r_wr_ready   <= ~w_step;
        end
    end

    assign w_wr_fire = wr_if.wr_valid & r_wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                r_mem[i] <= BLANK_CODE;
            end
        end else if (w_wr_fire) begin
            r_mem[wr_if.wr_addr] <= wr_if.wr_data;
        end
    end

    // Leftmost digit (an3) shows base; digit k shows base + (3 - k).
    assign w_rd_addr = r_base + ADDR_W'(2'd3 - w_digit);

    // Character is sampled once per slot, so a concurrent write shows from the next slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= AN_OFF;
            r_char <= BLANK_CODE;
        end else begin
            if (w_slot_start) begin
                r_char <= r_mem[w_rd_addr];
            end
            if (w_an_load) begin
                r_an <= anode_sel(w_digit);
            end else if (w_slot_start) begin
                r_an <= AN_OFF;
            end
        end
    end

    assign {o_an3, o_an2, o_an1, o_an0} = r_an;
    assign o_char         = r_char;
    assign o_step_pulse   = r_step_pulse;
    assign wr_if.wr_ready = r_wr_ready;

endmodule
